logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor to the fixed 32-bit gate-level logic cells.
//  One 3-bit opcode selects AND/OR/NOR/NAND/XOR/XNOR/NOT/PASS over WIDTH-bit A,B.

---
 rtl/logic_unit_pipe_pkg.sv | 17 +
 rtl/logic_unit_pipe_reduce_tree.sv | 40 ++++
 rtl/logic_unit_pipe.sv | 117 +++++++++++
 tb/tb_logic_unit_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - opcode encoding shared by the pipelined logic unit
// Purpose : opcode enumeration for logic_unit_pipe. It sits next to the ALU opcodes.
// Ports   : none (package)
package logic_unit_pipe_pkg;

   typedef enum logic [2:0] {
      LU_OP_AND  = 3'b000,
      LU_OP_OR   = 3'b001,
      LU_OP_NOR  = 3'b010,
      LU_OP_NAND = 3'b011,
      LU_OP_XOR  = 3'b100,
      LU_OP_XNOR = 3'b101,
      LU_OP_NOT  = 3'b110,
      LU_OP_PASS = 3'b111
   } lu_op_e;

endpackage

// File: rtl/logic_unit_pipe_reduce_tree.sv
// rtl/logic_unit_pipe_reduce_tree.sv - balanced OR/XOR reduction tree
// Purpose : reduces a WIDTH-bit word to any_one (OR of all bits) and parity
//           (XOR of all bits) through LOG_W levels of two-input nodes.
// Ports   : d       in  WIDTH  word to reduce
//           any_one out 1      1 when any bit of d is set
//           parity  out 1      XOR of all bits of d
module logic_unit_pipe_reduce_tree #(
   parameter int WIDTH = 32,
   parameter int LOG_W = 5
) (
   input  logic [WIDTH-1:0] d,
   output logic             any_one,
   output logic             parity
);

   localparam int N = 1 << LOG_W;

   logic [N-1:0] or_lvl;
   logic [N-1:0] xor_lvl;

   // The word is zero-padded to a power of two; zeros are neutral for both OR and
   // XOR. Each level folds pairs (2i, 2i+1) into slot i, so the lower half is
   // rewritten in place and slot 0 holds the root after LOG_W levels.
   always_comb begin
      or_lvl             = '0;
      xor_lvl            = '0;
      or_lvl[WIDTH-1:0]  = d;
      xor_lvl[WIDTH-1:0] = d;
      for (int l = 0; l < LOG_W; l++) begin
         for (int i = 0; i < (N >> (l + 1)); i++) begin
            or_lvl[i]  = or_lvl[2*i]  | or_lvl[2*i+1];
            xor_lvl[i] = xor_lvl[2*i] ^ xor_lvl[2*i+1];
         end
      end
   end

   assign any_one = or_lvl[0];
   assign parity  = xor_lvl[0];

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with ZERO/PARITY flags
// Purpose : applies one of eight bitwise ops (selected by OPC) to A/B. S1 registers
//           the raw result. S2 registers Y plus the ZERO and PARITY flags.
//           Valid/ready flow control gives 1 beat/cycle with 2-cycle latency.
// Ports   : CLK     in  1      rising-edge clock
//           RST     in  1      asynchronous active-high reset
//           IN_VLD  in  1      operand beat valid
//           IN_RDY  out 1      beat can be accepted this cycle
//           OPC     in  3      opcode, sampled with the beat
//           A, B    in  WIDTH  operands (B unused by NOT/PASS)
//           OUT_VLD out 1      result valid
//           OUT_RDY in  1      downstream accepts result
//           Y       out WIDTH  result
//           ZERO    out 1      Y == 0
//           PARITY  out 1      XOR of all bits of Y
module logic_unit_pipe
   import logic_unit_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LOG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VLD,
   output logic             IN_RDY,
   input  logic [2:0]       OPC,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VLD,
   input  logic             OUT_RDY,
   output logic [WIDTH-1:0] Y,
   output logic             ZERO,
   output logic             PARITY
);

   logic [WIDTH-1:0] r_and, r_or, r_nor, r_nand, r_xor, r_xnor, r_not, r_pass;
   logic [WIDTH-1:0] r_sel;
   logic [WIDTH-1:0] r1;
   logic             v1, v2;
   logic             rdy1, rdy2;
   logic             any_one, par1;

   // One gate of each kind per bit; the opcode then picks a column.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      and  u_and  (r_and[i],  A[i], B[i]);
      or   u_or   (r_or[i],   A[i], B[i]);
      nor  u_nor  (r_nor[i],  A[i], B[i]);
      nand u_nand (r_nand[i], A[i], B[i]);
      xor  u_xor  (r_xor[i],  A[i], B[i]);
      xnor u_xnor (r_xnor[i], A[i], B[i]);
      not  u_not  (r_not[i],  A[i]);
      buf  u_pass (r_pass[i], A[i]);
   end

   always_comb begin
      r_sel = r_pass;
      case (lu_op_e'(OPC))
         LU_OP_AND:  r_sel = r_and;
         LU_OP_OR:   r_sel = r_or;
         LU_OP_NOR:  r_sel = r_nor;
         LU_OP_NAND: r_sel = r_nand;
         LU_OP_XOR:  r_sel = r_xor;
         LU_OP_XNOR: r_sel = r_xnor;
         LU_OP_NOT:  r_sel = r_not;
         LU_OP_PASS: r_sel = r_pass;
         default:    r_sel = r_pass;
      endcase
   end

   // A stage may advance when it is empty or when the stage after it is advancing.
   // This lets a full pipe accept and retire in the same cycle.
   assign rdy2   = ~v2 | OUT_RDY;
   assign rdy1   = ~v1 | rdy2;
   assign IN_RDY = rdy1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1 <= 1'b0;
         r1 <= '0;
      end else if (rdy1) begin
         v1 <= IN_VLD;
         if (IN_VLD) begin
            r1 <= r_sel;
         end
      end
   end

   logic_unit_pipe_reduce_tree #(
      .WIDTH (WIDTH),
      .LOG_W (LOG_W)
   ) u_reduce_tree (
      .d       (r1),
      .any_one (any_one),
      .parity  (par1)
   );

   // Output registers load only when a real beat moves in. They keep their reset
   // value (including ZERO=0) until the first result arrives.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v2     <= 1'b0;
         Y      <= '0;
         ZERO   <= 1'b0;
         PARITY <= 1'b0;
      end else if (rdy2) begin
         v2 <= v1;
         if (v1) begin
            Y      <= r1;
            ZERO   <= ~any_one;
            PARITY <= par1;
         end
      end
   end

   assign OUT_VLD = v2;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef struct packed {
      logic [31:0] y;
      logic        zero;
      logic        parity;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VLD = 1'b0;
   logic        IN_RDY;
   logic [2:0]  OPC = 3'b000;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        OUT_VLD;
   logic        OUT_RDY = 1'b1;
   logic [31:0] Y;
   logic        ZERO;
   logic        PARITY;

   logic        in_vld8 = 1'b0;
   logic        in_rdy8;
   logic [2:0]  opc8 = 3'b000;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        out_vld8;
   logic [7:0]  y8;
   logic        zero8;
   logic        parity8;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb_q[$];

   logic        prev_stall = 1'b0;
   logic [31:0] prev_y = '0;
   logic        prev_zero = 1'b0;
   logic        prev_par = 1'b0;
   logic        rnd_phase = 1'b0;
   int          rnd_first = -1;
   int          rnd_last = -1;
   int          rnd_count = 0;
   int          bp_count = 0;
   logic        bp_phase = 1'b0;

   logic_unit_pipe #(.WIDTH(32), .LOG_W(5)) dut (
      .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .OPC(OPC),
      .A(A), .B(B), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .Y(Y),
      .ZERO(ZERO), .PARITY(PARITY)
   );

   logic_unit_pipe #(.WIDTH(8), .LOG_W(3)) dut8 (
      .CLK(CLK), .RST(RST), .IN_VLD(in_vld8), .IN_RDY(in_rdy8), .OPC(opc8),
      .A(a8), .B(b8), .OUT_VLD(out_vld8), .OUT_RDY(1'b1), .Y(y8),
      .ZERO(zero8), .PARITY(parity8)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_NOR:  return ~(a | b);
         OP_NAND: return ~(a & b);
         OP_XOR:  return a ^ b;
         OP_XNOR: return ~(a ^ b);
         OP_NOT:  return ~a;
         default: return a;
      endcase
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drive one beat and hold it until accepted; the expected result is queued at
   // the accepting edge.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_y);
      exp_t e;
      int   n;
      OPC = op; A = a; B = b; IN_VLD = 1'b1;
      n = 0;
      forever begin
         @(negedge CLK);
         if (IN_RDY) break;
         n++;
         if (n > 50) begin
            check("send_timeout", 32'(IN_RDY), 32'd1);
            break;
         end
      end
      e.y = exp_y; e.zero = (exp_y == 32'd0); e.parity = ^exp_y;
      sb_q.push_back(e);
      if (rnd_phase && rnd_first < 0) rnd_first = cyc;
      step();
      IN_VLD = 1'b0;
   endtask

   // Output side: pop and compare on every handshake, and check hold during stalls.
   always @(negedge CLK) begin
      if (RST) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_vld", 32'(OUT_VLD), 32'd1);
            check("stall_y", Y, prev_y);
            check("stall_flags", {30'd0, ZERO, PARITY}, {30'd0, prev_zero, prev_par});
         end
         if (OUT_VLD && OUT_RDY) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               exp_t e;
               e = sb_q.pop_front();
               check("y", Y, e.y);
               check("zero", 32'(ZERO), 32'(e.zero));
               check("parity", 32'(PARITY), 32'(e.parity));
            end
            if (rnd_phase) begin
               rnd_count++;
               rnd_last = cyc;
            end
            if (bp_phase) bp_count++;
         end
         prev_stall = OUT_VLD && !OUT_RDY;
         prev_y = Y; prev_zero = ZERO; prev_par = PARITY;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      check("drained", sb_q.size(), 32'd0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      int          n;

      // Reset state
      @(posedge CLK);
      #1;
      check("rst_out_vld", 32'(OUT_VLD), 32'd0);
      check("rst_y", Y, 32'd0);
      check("rst_zero", 32'(ZERO), 32'd0);
      check("rst_parity", 32'(PARITY), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("rst_in_rdy", 32'(IN_RDY), 32'd1);
      step();

      // Directed ops and flags
      send(OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
      send(OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
      send(OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
      send(OP_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000);
      send(OP_NOT,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0F0F_FF00);
      send(OP_NAND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF0F_FFF0);
      send(OP_XNOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00FF_F00F);
      send(OP_PASS, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF);
      send(OP_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000);
      send(OP_PASS, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007);
      drain();

      // Back-pressure: 5 beats, OUT_RDY low for cycles 3-6 of the stream
      bp_phase = 1'b1;
      fork
         begin
            send(OP_AND,  32'h1111_1111, 32'h0F0F_0F0F, 32'h0101_0101);
            send(OP_OR,   32'h1000_0000, 32'h0000_0001, 32'h1000_0001);
            send(OP_XOR,  32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
            send(OP_NOT,  32'hFFFF_0000, 32'h0,         32'h0000_FFFF);
            send(OP_PASS, 32'h1234_5678, 32'h0,         32'h1234_5678);
         end
         begin
            repeat (2) step();
            OUT_RDY = 1'b0;
            @(negedge CLK);
            check("full_in_rdy", 32'(IN_RDY), 32'd0);
            check("full_out_vld", 32'(OUT_VLD), 32'd1);
            repeat (4) step();
            OUT_RDY = 1'b1;
         end
      join
      drain();
      check("bp_count", bp_count, 32'd5);
      bp_phase = 1'b0;

      // Reset mid-operation drops in-flight beats
      OUT_RDY = 1'b0;
      send(OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
      send(OP_OR, 32'h0000_0F00, 32'h0000_0001, 32'h0000_0F01);
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      check("midrst_out_vld", 32'(OUT_VLD), 32'd0);
      check("midrst_y", Y, 32'd0);
      check("midrst_zero", 32'(ZERO), 32'd0);
      sb_q.delete();
      step();
      RST = 1'b0;
      OUT_RDY = 1'b1;
      @(negedge CLK);
      check("midrst_in_rdy", 32'(IN_RDY), 32'd1);
      check("midrst_idle", 32'(OUT_VLD), 32'd0);
      step();

      // Throughput: 100 random back-to-back beats
      rnd_phase = 1'b1;
      for (int k = 0; k < 100; k++) begin
         op = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         send(op, ra, rb, model(op, ra, rb));
      end
      drain();
      rnd_phase = 1'b0;
      check("rnd_count", rnd_count, 32'd100);
      check("rnd_cycles", 32'(rnd_last - rnd_first + 1), 32'd102);

      // WIDTH=8 build
      opc8 = OP_NAND; a8 = 8'hAA; b8 = 8'hFF; in_vld8 = 1'b1;
      step();
      in_vld8 = 1'b0;
      n = 0;
      while (!out_vld8 && n < 20) begin
         step();
         n++;
      end
      check("w8_vld", 32'(out_vld8), 32'd1);
      check("w8_y", 32'(y8), 32'h55);
      check("w8_parity", 32'(parity8), 32'd0);
      check("w8_zero", 32'(zero8), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
